// File: rtl/queue_reader.sv
// -----------------------------------------------------------------------------
// queue_reader
//
// Read-side controller for a queue_reg shift-register queue. It keeps a
// mirror of the queue occupancy from the writer's push strobe, issues
// read_flag only when a word is present and there is room downstream, absorbs
// the queue's one-cycle read latency, and presents the words on a
// valid/ready stream with a per-frame last marker.
//
// Ports
//   clk      : clock, all state on the rising edge
//   rst      : asynchronous reset, active low
//   q_push   : copy of the queue's input_vld (a write into the queue)
//   q_read   : drives the queue's read_flag
//   q_dout   : queue data, valid the cycle after q_read
//   m_valid  : output word valid
//   m_ready  : downstream accept
//   m_data   : output word (FIFO head)
//   m_last   : high with the last word of a frame
//   occ      : mirrored queue occupancy
//   err_ovf  : sticky flag, push while the queue was full with no read
//   err_clr  : synchronous clear of err_ovf (a new overflow wins)
// -----------------------------------------------------------------------------
module queue_reader #(
  parameter int width     = 8,
  parameter int depth     = 3,
  parameter int frame_len = 9
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         q_push,
  output logic                         q_read,
  input  logic [width-1:0]             q_dout,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [width-1:0]             m_data,
  output logic                         m_last,
  output logic [$clog2(depth+1)-1:0]   occ,
  output logic                         err_ovf,
  input  logic                         err_clr
);

  localparam int OCC_W  = $clog2(depth + 1);
  localparam int FCNT_W = (frame_len > 1) ? $clog2(frame_len) : 1;

  localparam logic [OCC_W-1:0]  OCC_FULL  = OCC_W'(depth);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(frame_len - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [OCC_W-1:0]  occ_q,     occ_d;
  logic              pend_q,    pend_d;
  logic [1:0]        buf_cnt_q, buf_cnt_d;
  logic              wr_ptr_q,  wr_ptr_d;
  logic              rd_ptr_q,  rd_ptr_d;
  logic [FCNT_W-1:0] fcnt_q,    fcnt_d;
  logic              err_ovf_q, err_ovf_d;

  // Two-entry output FIFO; the last marker is stamped next to each word.
  logic [width-1:0]  buf_data_q [2];
  logic [width-1:0]  buf_data_d [2];
  logic              buf_last_q [2];
  logic              buf_last_d [2];

  // ---------------------------------------------------------------------------
  // Handshake and read issue
  // ---------------------------------------------------------------------------
  logic       pop;
  logic [2:0] room_used;

  always_comb begin
    pop = (buf_cnt_q != 2'd0) && m_ready;

    // Entries that will be held or in flight after this cycle's pop. A read
    // issued now lands one cycle later, so pend counts as already occupying
    // a slot; keeping this below two means the FIFO can never overflow.
    room_used = {1'b0, buf_cnt_q} + {2'b00, pend_q} - {2'b00, pop};

    // Only registered state feeds the occupancy term: a word pushed this
    // cycle is not readable until the next one.
    q_read = (occ_q != '0) && (room_used < 3'd2);
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    occ_d      = occ_q;
    err_ovf_d  = err_ovf_q;
    pend_d     = q_read;
    buf_cnt_d  = buf_cnt_q + {1'b0, pend_q} - {1'b0, pop};
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fcnt_d     = fcnt_q;
    buf_data_d = buf_data_q;
    buf_last_d = buf_last_q;

    // Occupancy mirror. A push into a full queue without a read is lost by
    // the queue itself, so the count saturates and the error is flagged.
    if (q_push && !q_read) begin
      if (occ_q == OCC_FULL) begin
        occ_d = occ_q;
      end else begin
        occ_d = occ_q + OCC_W'(1);
      end
    end else if (q_read && !q_push) begin
      occ_d = occ_q - OCC_W'(1);
    end

    if (err_clr) begin
      err_ovf_d = 1'b0;
    end
    if (q_push && !q_read && (occ_q == OCC_FULL)) begin
      err_ovf_d = 1'b1;
    end

    // Capture the word requested last cycle into the FIFO tail.
    if (pend_q) begin
      buf_data_d[wr_ptr_q] = q_dout;
      buf_last_d[wr_ptr_q] = (fcnt_q == FCNT_LAST);
      wr_ptr_d             = ~wr_ptr_q;
      if (fcnt_q == FCNT_LAST) begin
        fcnt_d = '0;
      end else begin
        fcnt_d = fcnt_q + FCNT_W'(1);
      end
    end

    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q     <= '0;
      pend_q    <= 1'b0;
      buf_cnt_q <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      fcnt_q    <= '0;
      err_ovf_q <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        buf_data_q[i] <= '0;
        buf_last_q[i] <= 1'b0;
      end
    end else begin
      occ_q     <= occ_d;
      pend_q    <= pend_d;
      buf_cnt_q <= buf_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fcnt_q    <= fcnt_d;
      err_ovf_q <= err_ovf_d;
      for (int unsigned i = 0; i < 2; i++) begin
        buf_data_q[i] <= buf_data_d[i];
        buf_last_q[i] <= buf_last_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (head of the FIFO and registered counters)
  // ---------------------------------------------------------------------------
  assign m_valid = (buf_cnt_q != 2'd0);
  assign m_data  = buf_data_q[rd_ptr_q];
  assign m_last  = buf_last_q[rd_ptr_q];
  assign occ     = occ_q;
  assign err_ovf = err_ovf_q;

endmodule

// File: tb/tb_queue_reader.sv
// -----------------------------------------------------------------------------
// tb_queue_reader
//
// Directed bench for queue_reader. A behavioural queue_reg (registered dout,
// capacity 3, drops pushes when full without a read) sits on the read side.
// -----------------------------------------------------------------------------
module tb_queue_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       q_push;
  logic       q_read;
  logic [7:0] q_dout;
  logic [7:0] q_din;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_last;
  logic [1:0] occ;
  logic       err_ovf;
  logic       err_clr;

  always #5 clk = ~clk;

  queue_reader #(
    .width    (8),
    .depth    (3),
    .frame_len(9)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .q_push (q_push),
    .q_read (q_read),
    .q_dout (q_dout),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data (m_data),
    .m_last (m_last),
    .occ    (occ),
    .err_ovf(err_ovf),
    .err_clr(err_clr)
  );

  // Attached queue model: strobes are latched mid-cycle, applied on the edge.
  logic [7:0] mq [$];
  logic       rd_l, push_l;
  logic [7:0] din_l;

  always @(negedge clk) begin
    rd_l   = q_read;
    push_l = q_push;
    din_l  = q_din;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      q_dout <= 8'h00;
    end else begin
      if (rd_l && mq.size() > 0) q_dout <= mq.pop_front();
      if (push_l && mq.size() < 3) mq.push_back(din_l);
    end
  end

  // Bookkeeping
  int n_checks = 0;
  int n_fail   = 0;
  int cyc, rd_cnt, first_rd, first_vld;
  logic [7:0] pop_data [$];
  logic       pop_last [$];
  int         pop_cyc  [$];

  task automatic clear_log();
    cyc = 0; rd_cnt = 0; first_rd = -1; first_vld = -1;
    pop_data.delete(); pop_last.delete(); pop_cyc.delete();
  endtask

  // One clock cycle: inputs already set at posedge+1, observe at negedge.
  task automatic cycle();
    @(negedge clk);
    if (q_read) begin
      rd_cnt++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (m_valid && first_vld < 0) first_vld = cyc;
    if (m_valid && m_ready) begin
      pop_data.push_back(m_data);
      pop_last.push_back(m_last);
      pop_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push_word(input logic [7:0] d);
    q_push = 1'b1; q_din = d;
    cycle();
    q_push = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b0; q_push = 1'b0; q_din = 8'h00; m_ready = 1'b0; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (q_read  !== 1'b0)  begin n_fail++; $display("FAIL reset_q_read: got %b want 0", q_read); end
    n_checks++; if (m_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
    n_checks++; if (m_data  !== 8'h00) begin n_fail++; $display("FAIL reset_m_data: got %h want 00", m_data); end
    n_checks++; if (m_last  !== 1'b0)  begin n_fail++; $display("FAIL reset_m_last: got %b want 0", m_last); end
    n_checks++; if (occ     !== 2'd0)  begin n_fail++; $display("FAIL reset_occ: got %0d want 0", occ); end
    n_checks++; if (err_ovf !== 1'b0)  begin n_fail++; $display("FAIL reset_err_ovf: got %b want 0", err_ovf); end
    rst = 1'b1;
    clear_log();
    repeat (20) cycle();
    n_checks++; if (rd_cnt !== 0)     begin n_fail++; $display("FAIL idle_q_read: got %0d pulses want 0", rd_cnt); end
    n_checks++; if (first_vld !== -1) begin n_fail++; $display("FAIL idle_m_valid: first at %0d want never", first_vld); end
    n_checks++; if (occ !== 2'd0)     begin n_fail++; $display("FAIL idle_occ: got %0d want 0", occ); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_basic();
    logic [7:0] exp_d [3];
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
    clear_log();
    m_ready = 1'b1;
    q_push = 1'b1;
    q_din = 8'h11; cycle();
    q_din = 8'h22; cycle();
    q_din = 8'h33; cycle();
    q_push = 1'b0;
    repeat (5) cycle();
    n_checks++; if (first_rd !== 1)  begin n_fail++; $display("FAIL basic_first_read: got cycle %0d want 1", first_rd); end
    n_checks++; if (first_vld !== 3) begin n_fail++; $display("FAIL basic_first_valid: got cycle %0d want 3", first_vld); end
    n_checks++; if (pop_data.size() !== 3) begin n_fail++; $display("FAIL basic_count: got %0d words want 3", pop_data.size()); end
    for (int i = 0; i < 3; i++) begin
      if (pop_data.size() > i) begin
        n_checks++; if (pop_data[i] !== exp_d[i]) begin n_fail++; $display("FAIL basic_data%0d: got %h want %h", i, pop_data[i], exp_d[i]); end
        n_checks++; if (pop_cyc[i] !== 3 + i)     begin n_fail++; $display("FAIL basic_cycle%0d: got %0d want %0d", i, pop_cyc[i], 3 + i); end
      end
    end
    n_checks++; if (occ !== 2'd0)    begin n_fail++; $display("FAIL basic_occ: got %0d want 0", occ); end
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drained: m_valid %b want 0", m_valid); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_backpressure();
    clear_log();
    m_ready = 1'b0;
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    repeat (7) cycle();
    n_checks++; if (rd_cnt !== 2)       begin n_fail++; $display("FAIL bp_reads: got %0d pulses want 2", rd_cnt); end
    n_checks++; if (occ !== 2'd1)       begin n_fail++; $display("FAIL bp_occ: got %0d want 1", occ); end
    n_checks++; if (m_valid !== 1'b1)   begin n_fail++; $display("FAIL bp_valid: got %b want 1", m_valid); end
    n_checks++; if (m_data !== 8'h11)   begin n_fail++; $display("FAIL bp_hold_data: got %h want 11", m_data); end
  endtask

  // ---------------------------------------------------------------------------
  // Continues from backpressure: FIFO holds 11,22 and the queue holds 33.
  task automatic test_overflow();
    logic [7:0] exp_d [6];
    logic       exp_l [6];
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
    exp_d[3] = 8'h44; exp_d[4] = 8'h55; exp_d[5] = 8'h88;
    // Frame counter has stamped 0..2 earlier, so these get 3..8.
    for (int i = 0; i < 6; i++) exp_l[i] = (i == 5);
    clear_log();
    push_word(8'h44);
    push_word(8'h55);
    n_checks++; if (rd_cnt !== 0) begin n_fail++; $display("FAIL ovf_no_read: got %0d pulses want 0", rd_cnt); end
    n_checks++; if (occ !== 2'd3) begin n_fail++; $display("FAIL ovf_full_occ: got %0d want 3", occ); end
    push_word(8'h66);
    n_checks++; if (err_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", err_ovf); end
    n_checks++; if (occ !== 2'd3)     begin n_fail++; $display("FAIL ovf_occ_hold: got %0d want 3", occ); end
    err_clr = 1'b1;
    push_word(8'h77);
    n_checks++; if (err_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set_priority: got %b want 1", err_ovf); end
    cycle();
    err_clr = 1'b0;
    n_checks++; if (err_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", err_ovf); end
    n_checks++; if (occ !== 2'd3)     begin n_fail++; $display("FAIL ovf_occ_after_clr: got %0d want 3", occ); end
    clear_log();
    m_ready = 1'b1;
    push_word(8'h88);
    n_checks++; if (rd_cnt !== 1)     begin n_fail++; $display("FAIL ovf_push_read: got %0d pulses want 1", rd_cnt); end
    n_checks++; if (occ !== 2'd3)     begin n_fail++; $display("FAIL ovf_push_read_occ: got %0d want 3", occ); end
    n_checks++; if (err_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_push_read_err: got %b want 0", err_ovf); end
    for (int t = 0; t < 20 && pop_data.size() < 6; t++) cycle();
    n_checks++; if (pop_data.size() !== 6) begin n_fail++; $display("FAIL drain_count: got %0d words want 6", pop_data.size()); end
    for (int i = 0; i < 6; i++) begin
      if (pop_data.size() > i) begin
        n_checks++; if (pop_data[i] !== exp_d[i]) begin n_fail++; $display("FAIL drain_data%0d: got %h want %h", i, pop_data[i], exp_d[i]); end
        n_checks++; if (pop_cyc[i] !== i)         begin n_fail++; $display("FAIL drain_rate%0d: got cycle %0d want %0d", i, pop_cyc[i], i); end
        n_checks++; if (pop_last[i] !== exp_l[i]) begin n_fail++; $display("FAIL drain_last%0d: got %b want %b", i, pop_last[i], exp_l[i]); end
      end
    end
    n_checks++; if (occ !== 2'd0) begin n_fail++; $display("FAIL drain_occ: got %0d want 0", occ); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_frames();
    logic [31:0] rdy_pat;
    logic        hold, hold_last;
    logic [7:0]  hold_data;
    int          sent;
    rdy_pat = 32'b1011_0010_1110_0101_1001_1101_0110_0011;
    rst = 1'b0; q_push = 1'b0; m_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    clear_log();
    sent = 0; hold = 1'b0; hold_data = 8'h00; hold_last = 1'b0;
    for (int t = 0; t < 400 && pop_data.size() < 20; t++) begin
      if (hold) begin
        n_checks++; if (m_valid !== 1'b1)       begin n_fail++; $display("FAIL stable_valid t%0d: got %b want 1", t, m_valid); end
        n_checks++; if (m_data !== hold_data)   begin n_fail++; $display("FAIL stable_data t%0d: got %h want %h", t, m_data, hold_data); end
        n_checks++; if (m_last !== hold_last)   begin n_fail++; $display("FAIL stable_last t%0d: got %b want %b", t, m_last, hold_last); end
      end
      q_push = (sent < 20) && (mq.size() < 3);
      q_din  = 8'hA0 + 8'(sent);
      if (q_push) sent++;
      m_ready   = rdy_pat[t % 32];
      hold      = m_valid && !m_ready;
      hold_data = m_data;
      hold_last = m_last;
      cycle();
    end
    q_push = 1'b0;
    n_checks++; if (pop_data.size() !== 20) begin n_fail++; $display("FAIL frame_count: got %0d words want 20", pop_data.size()); end
    for (int i = 0; i < 20; i++) begin
      if (pop_data.size() > i) begin
        n_checks++; if (pop_data[i] !== 8'hA0 + 8'(i)) begin n_fail++; $display("FAIL frame_data%0d: got %h want %h", i, pop_data[i], 8'hA0 + 8'(i)); end
        n_checks++; if (pop_last[i] !== (i == 8 || i == 17)) begin n_fail++; $display("FAIL frame_last%0d: got %b want %b", i, pop_last[i], (i == 8 || i == 17)); end
      end
    end
    n_checks++; if (err_ovf !== 1'b0) begin n_fail++; $display("FAIL frame_err: got %b want 0", err_ovf); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_midstream();
    clear_log();
    m_ready = 1'b0;
    push_word(8'hF1);
    push_word(8'hF2);
    push_word(8'hF3);
    n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: got %b want 1", m_valid); end
    #2;
    rst = 1'b0;
    #1;
    n_checks++; if (q_read  !== 1'b0)  begin n_fail++; $display("FAIL mid_q_read: got %b want 0", q_read); end
    n_checks++; if (m_valid !== 1'b0)  begin n_fail++; $display("FAIL mid_m_valid: got %b want 0", m_valid); end
    n_checks++; if (m_data  !== 8'h00) begin n_fail++; $display("FAIL mid_m_data: got %h want 00", m_data); end
    n_checks++; if (m_last  !== 1'b0)  begin n_fail++; $display("FAIL mid_m_last: got %b want 0", m_last); end
    n_checks++; if (occ     !== 2'd0)  begin n_fail++; $display("FAIL mid_occ: got %0d want 0", occ); end
    @(posedge clk); #1;
    rst = 1'b1;
    clear_log();
    m_ready = 1'b1;
    for (int i = 0; i < 9; i++) push_word(8'hB0 + 8'(i));
    for (int t = 0; t < 30 && pop_data.size() < 9; t++) cycle();
    n_checks++; if (pop_data.size() !== 9) begin n_fail++; $display("FAIL after_count: got %0d words want 9", pop_data.size()); end
    for (int i = 0; i < 9; i++) begin
      if (pop_data.size() > i) begin
        n_checks++; if (pop_data[i] !== 8'hB0 + 8'(i)) begin n_fail++; $display("FAIL after_data%0d: got %h want %h", i, pop_data[i], 8'hB0 + 8'(i)); end
        n_checks++; if (pop_last[i] !== (i == 8)) begin n_fail++; $display("FAIL after_last%0d: got %b want %b", i, pop_last[i], (i == 8)); end
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_frames();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
